ln_mean_acc: RTL and testbench
==============================

# ln_mean_acc

Downstream consumer of the 8-bit natural-log stage: registers the stage's `n_var` results through a valid/ready handshake and accumulates blocks of 2^LOG2_N samples. Per block, it emits the arithmetic mean in the log domain (the log of the geometric mean) together with the block minimum and maximum. It sits between the combinational `n_var` output and any sequential consumer, and gives the log datapath its first clocked, back-pressurable interface. Input and output share one fixed-point format: unsigned Q3.5 (ln(255) ≈ 5.54 → 8'd177).

## Interface
- `LOG2_N`, default 3: block length N = 2^LOG2_N samples; legal range 0..6.
- `W`, default 8: sample width; must match `n_var`.

- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `clear`  in  1  synchronous block abort; discards the partial block.
- `in_valid`  in  1  `in_ln` holds a sample.
- `in_ready`  out  1  block can accept a sample.
- `in_ln`  in  W  log sample, Q3.5.
- `out_valid`  out  1  result registers hold a completed block.
- `out_ready`  in  1  consumer accepts the result.
- `out_mean`  out  W  block mean, Q3.5.
- `out_min`  out  W  smallest sample in the block.
- `out_max`  out  W  largest sample in the block.

## Operation
- States:
  - ACC: `in_ready`=1, `out_valid`=0.
  - HOLD: `in_ready`=0, `out_valid`=1.
- Input transfer: `in_valid && in_ready` on a rising edge.
- Output transfer: `out_valid && out_ready` on a rising edge.
- ACC, each input transfer:
  - sum += in_ln.
  - min/max updated; the first sample of a block loads both directly.
  - cnt += 1.
- On the transfer that makes cnt = N:
  - out_mean, out_min and out_max are loaded.
  - sum, cnt and the min/max trackers are reset to zero.
  - The state goes to HOLD.
- HOLD:
  - Results stay stable until an output transfer.
  - On the output transfer, the state returns to ACC.
  - No input transfer can occur while in HOLD.
- Accumulator width is W+LOG2_N bits, so the sum cannot overflow (255·64 < 2^14).
- Mean = sum >> LOG2_N (truncating; see Configuration).
- `cnt` is LOG2_N+1 bits wide, cleared when a block completes, and never wraps mid-block.
- `clear`:
  - Zeroes sum, cnt and the trackers, and forces ACC.
  - In HOLD, the pending result is dropped: `out_valid` goes 0 and the result registers are zeroed.
  - Takes precedence over a simultaneous input or output transfer; the sample or result in that transfer is discarded.
- LOG2_N = 0: every accepted sample completes a block; mean = min = max = sample.
- `rst_n` low at any time, including mid-block or in HOLD: all state and outputs are cleared immediately and the state is ACC.

## Timing
- Reset values:
  - `in_ready`=1 once `rst_n` deasserts (0 while `rst_n` is low).
  - `out_valid`=0.
  - `out_mean` = `out_min` = `out_max` = 0.
- Latency: `out_valid` rises on the same edge that accepts the Nth sample, so it is visible in the cycle after that transfer.
- Throughput: one block per N+1 cycles when `out_ready` is held at 1, because HOLD costs one cycle.
- Outputs are registered; `in_ready` and `out_valid` are decoded from state with no combinational path from `in_valid` or `out_ready`.
- While `out_ready`=0, `out_valid` and all result bits hold unchanged for any number of cycles.

## Configuration
- Macro: `LN_MEAN_ROUND_EN`.
- Defined: mean = (sum + 2^(LOG2_N−1)) >> LOG2_N, round-half-up. There is no rounding term when LOG2_N = 0. The result cannot exceed 255 because 255·N + N/2 < 256·N.
- Undefined: mean = sum >> LOG2_N, truncating toward zero.
- Ports and timing are identical in both builds.

## Structure
- Shared package `ln_pkg`:
  - Q3.5 format constants: `LN_FRAC_BITS`=5, `LN_W`=8.
  - State enum `ln_acc_state_t` {ACC, HOLD}.
  - Reference constants `LN_Q_1`=8'd0 and `LN_Q_255`=8'd177.
- One natural sub-module: `ln_minmax_track`, the running min/max register pair with a first-sample load and a clear input.
- Control and accumulation stay in the top.

## Test plan
- 8 samples of 8'd22 (ln 2), out_ready=1 → out_mean=22, out_min=22, out_max=22. `out_valid` is high exactly one cycle, in the cycle after the 8th transfer.
- Samples 0..7 (sum 28) → out_mean=3 without `LN_MEAN_ROUND_EN`, 4 with it; out_min=0, out_max=7.
- Full block, then out_ready=0 for 5 cycles → outputs stable and in_ready=0 throughout; after out_ready=1, in_ready=1 on the next cycle.
- Assert `clear` after 3 samples, then send 8 samples of 8'd177 → out_mean=177, out_min=177, out_max=177 (the partial block is discarded).
- Pulse `rst_n` low while in HOLD → out_valid=0, in_ready=1, and all result ports read 0.
- LOG2_N=0 build, samples 5 and 9 → two consecutive results: mean/min/max = 5, then 9.

Source files
------------

// File: rtl/ln_pkg.sv
// Shared definitions for the Q3.5 natural-log datapath: format constants,
// reference codes and the accumulator state encoding.
package ln_pkg;

  localparam int LN_FRAC_BITS = 5;
  localparam int LN_W         = 8;

  localparam logic [LN_W-1:0] LN_Q_1   = 8'd0;
  localparam logic [LN_W-1:0] LN_Q_255 = 8'd177;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } ln_acc_state_t;

endpackage

// File: rtl/ln_mean_acc_if.sv
// Sample-in / result-out handshake bundle for ln_mean_acc.
// The slave modport is the accumulator side; master is the producer/consumer side.
interface ln_mean_acc_if #(
  parameter int W = 8
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_ln;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_mean;
  logic [W-1:0] out_min;
  logic [W-1:0] out_max;

  modport slave (
    input  in_valid, in_ln, out_ready,
    output in_ready, out_valid, out_mean, out_min, out_max
  );

  modport master (
    output in_valid, in_ln, out_ready,
    input  in_ready, out_valid, out_mean, out_min, out_max
  );

endinterface

// File: rtl/ln_mean_acc_minmax_track.sv
// Running min/max register pair. nxt_min/nxt_max present the tracker value
// including the current sample so the block's last sample can be folded in.
module ln_minmax_track #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         en,
  input  logic         first,
  input  logic [W-1:0] d,
  output logic [W-1:0] nxt_min,
  output logic [W-1:0] nxt_max
);

  logic [W-1:0] cur_min;
  logic [W-1:0] cur_max;

  always_comb begin
    nxt_min = cur_min;
    nxt_max = cur_max;
    if (first) begin
      nxt_min = d;
      nxt_max = d;
    end else begin
      if (d < cur_min) nxt_min = d;
      if (d > cur_max) nxt_max = d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_min <= '0;
      cur_max <= '0;
    end else if (clear) begin
      cur_min <= '0;
      cur_max <= '0;
    end else if (en) begin
      cur_min <= nxt_min;
      cur_max <= nxt_max;
    end
  end

endmodule

// File: rtl/ln_mean_acc.sv
// Block accumulator for Q3.5 log samples: emits mean, min and max per 2^LOG2_N samples.
// Define LN_MEAN_ROUND_EN for round-half-up mean; default build truncates.
import ln_pkg::*;

module ln_mean_acc #(
  parameter int LOG2_N = 3,
  parameter int W      = LN_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  ln_mean_acc_if.slave    bus
);

  localparam int N  = 1 << LOG2_N;
  localparam int SW = W + LOG2_N;
  localparam int CW = LOG2_N + 1;

  ln_acc_state_t state;
  ln_acc_state_t state_nxt;

  logic [SW-1:0] sum;
  logic [SW-1:0] sum_next;
  logic [CW-1:0] cnt;
  logic [W-1:0]  mean_nxt;
  logic [W-1:0]  min_nxt;
  logic [W-1:0]  max_nxt;
  logic          take;
  logic          done;

  assign bus.in_ready  = (state == ACC) && rst_n;
  assign bus.out_valid = (state == HOLD);

  assign take     = bus.in_valid && bus.in_ready;
  assign done     = take && (cnt == CW'(N - 1));
  assign sum_next = sum + SW'(bus.in_ln);

`ifdef LN_MEAN_ROUND_EN
  // N/2 is zero for LOG2_N = 0, so the single-sample case needs no special path.
  localparam logic [SW-1:0] HALF = SW'(N / 2);
  assign mean_nxt = W'((sum_next + HALF) >> LOG2_N);
`else
  assign mean_nxt = W'(sum_next >> LOG2_N);
`endif

  ln_minmax_track #(
    .W(W)
  ) u_track (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear || done),
    .en      (take),
    .first   (cnt == '0),
    .d       (bus.in_ln),
    .nxt_min (min_nxt),
    .nxt_max (max_nxt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ACC:  if (done) state_nxt = HOLD;
      HOLD: if (bus.out_ready) state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
    if (clear) state_nxt = ACC;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACC;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
      cnt <= '0;
    end else if (clear || done) begin
      sum <= '0;
      cnt <= '0;
    end else if (take) begin
      sum <= sum_next;
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_mean <= '0;
      bus.out_min  <= '0;
      bus.out_max  <= '0;
    end else if (clear) begin
      bus.out_mean <= '0;
      bus.out_min  <= '0;
      bus.out_max  <= '0;
    end else if (done) begin
      bus.out_mean <= mean_nxt;
      bus.out_min  <= min_nxt;
      bus.out_max  <= max_nxt;
    end
  end

endmodule

// File: tb/tb_ln_mean_acc.sv
// Scoreboard bench for ln_mean_acc: N=8 instance plus a LOG2_N=0 instance.
module tb_ln_mean_acc;

  typedef struct packed {
    logic [7:0] mean;
    logic [7:0] min;
    logic [7:0] max;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic clear_a;
  logic clear_b;

  int checks = 0;
  int errors = 0;

  exp_t qa[$];
  exp_t qb[$];

  ln_mean_acc_if #(.W(8)) bus_a ();
  ln_mean_acc_if #(.W(8)) bus_b ();

  ln_mean_acc #(.LOG2_N(3), .W(8)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear_a),
    .bus   (bus_a)
  );

  ln_mean_acc #(.LOG2_N(0), .W(8)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear_b),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (rst_n && bus_a.out_valid && bus_a.out_ready) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_result: got mean %0d expected no result", bus_a.out_mean);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_mean", bus_a.out_mean, e.mean);
        chk("a_min",  bus_a.out_min,  e.min);
        chk("a_max",  bus_a.out_max,  e.max);
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (rst_n && bus_b.out_valid && bus_b.out_ready) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_result: got mean %0d expected no result", bus_b.out_mean);
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_mean", bus_b.out_mean, e.mean);
        chk("b_min",  bus_b.out_min,  e.min);
        chk("b_max",  bus_b.out_max,  e.max);
      end
    end
  end

  // Callers start at a negedge; returns at the negedge after the transfer.
  task automatic send_a(input logic [7:0] d);
    int unsigned t = 0;
    while (!bus_a.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus_a.in_ready) begin
      checks++;
      errors++;
      $display("FAIL a_send_timeout: got in_ready 0 expected 1");
    end
    bus_a.in_valid = 1'b1;
    bus_a.in_ln    = d;
    @(negedge clk);
    bus_a.in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d);
    int unsigned t = 0;
    while (!bus_b.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus_b.in_ready) begin
      checks++;
      errors++;
      $display("FAIL b_send_timeout: got in_ready 0 expected 1");
    end
    bus_b.in_valid = 1'b1;
    bus_b.in_ln    = d;
    @(negedge clk);
    bus_b.in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] mix [8];
    int mean01;
    mix = '{8'd200, 8'd3, 8'd150, 8'd77, 8'd9, 8'd255, 8'd1, 8'd100};
`ifdef LN_MEAN_ROUND_EN
    mean01 = 4;
`else
    mean01 = 3;
`endif

    rst_n = 1'b0;
    clear_a = 1'b0;
    clear_b = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.in_ln = '0; bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_ln = '0; bus_b.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_in_ready_low", bus_a.in_ready, 0);
    chk("rst_out_valid",    bus_a.out_valid, 0);
    chk("rst_out_mean",     bus_a.out_mean, 0);
    chk("rst_out_min",      bus_a.out_min, 0);
    chk("rst_out_max",      bus_a.out_max, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready_high", bus_a.in_ready, 1);

    // Constant block, one-cycle HOLD
    bus_a.out_ready = 1'b1;
    qa.push_back('{8'd22, 8'd22, 8'd22});
    for (int i = 0; i < 8; i++) send_a(8'd22);
    chk("t1_valid_after_8th", bus_a.out_valid, 1);
    chk("t1_in_ready_hold",   bus_a.in_ready, 0);
    @(negedge clk);
    chk("t1_valid_one_cycle", bus_a.out_valid, 0);
    chk("t1_in_ready_back",   bus_a.in_ready, 1);

    // Ramp 0..7
    qa.push_back('{8'(mean01), 8'd0, 8'd7});
    for (int i = 0; i < 8; i++) send_a(8'(i));
    @(negedge clk);

    // Back-pressure: result must hold for 5 cycles
    bus_a.out_ready = 1'b0;
    qa.push_back('{8'd36, 8'd8, 8'd64});
    for (int i = 1; i <= 8; i++) send_a(8'(8 * i));
    for (int i = 0; i < 5; i++) begin
      chk("t3_stall_valid",    bus_a.out_valid, 1);
      chk("t3_stall_in_ready", bus_a.in_ready, 0);
      chk("t3_stall_mean",     bus_a.out_mean, 36);
      chk("t3_stall_min",      bus_a.out_min, 8);
      chk("t3_stall_max",      bus_a.out_max, 64);
      @(negedge clk);
    end
    bus_a.out_ready = 1'b1;
    @(negedge clk);
    chk("t3_in_ready_after", bus_a.in_ready, 1);
    chk("t3_valid_after",    bus_a.out_valid, 0);

    // Clear discards a partial block
    for (int i = 0; i < 3; i++) send_a(8'd99);
    clear_a = 1'b1;
    @(negedge clk);
    clear_a = 1'b0;
    qa.push_back('{8'd177, 8'd177, 8'd177});
    for (int i = 0; i < 8; i++) send_a(8'd177);
    @(negedge clk);

    // Async reset while holding a result
    bus_a.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_a(8'd50);
    chk("t5_hold_before_rst", bus_a.out_valid, 1);
    rst_n = 1'b0;
    #2;
    chk("t5_in_ready_in_rst", bus_a.in_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_valid_after_rst",    bus_a.out_valid, 0);
    chk("t5_in_ready_after_rst", bus_a.in_ready, 1);
    chk("t5_mean_after_rst",     bus_a.out_mean, 0);
    chk("t5_min_after_rst",      bus_a.out_min, 0);
    chk("t5_max_after_rst",      bus_a.out_max, 0);
    bus_a.out_ready = 1'b1;

    // Mixed extremes: sum 795 -> 99 either way
    qa.push_back('{8'd99, 8'd1, 8'd255});
    for (int i = 0; i < 8; i++) send_a(mix[i]);
    @(negedge clk);

    // Single-sample blocks
    qb.push_back('{8'd5, 8'd5, 8'd5});
    qb.push_back('{8'd9, 8'd9, 8'd9});
    send_b(8'd5);
    send_b(8'd9);
    @(negedge clk);

    for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++) @(negedge clk);
    chk("drain_qa", qa.size(), 0);
    chk("drain_qb", qb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
